// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the symbol-width-converting FIFO.
// Pure elaboration-time content; no logic.
package fifo_pkg;

  localparam int MODE_UNPACK = 0;
  localparam int MODE_PACK   = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_sym_ram.sv
// Symbol store: NSIZE write lanes into one aligned group, RS-symbol aligned async read.
// No reset; contents are only reachable through the owner's pointers.
module fifo_sym_ram #(
  parameter int DSIZE = 8,
  parameter int NSIZE = 4,
  parameter int DEPTH = 16,
  parameter int RS    = 1,
  parameter int AW    = 4
) (
  input  logic                         clk_i,
  input  logic [NSIZE-1:0]             we_i,
  input  logic [AW-1:0]                wbase_i,
  input  logic [NSIZE*(DSIZE+1)-1:0]   wdat_i,
  input  logic [AW-1:0]                raddr_i,
  output logic [RS*(DSIZE+1)-1:0]      rdat_o
);

  localparam int SW = DSIZE + 1;

  logic [SW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NSIZE; j++) begin
      if (we_i[j]) mem_q[wbase_i + AW'(j)] <= wdat_i[j*SW +: SW];
    end
  end

  // Lane k of the read port is the k-th symbol after the aligned read address.
  always_comb begin
    rdat_o = '0;
    for (int k = 0; k < RS; k++) begin
      rdat_o[k*SW +: SW] = mem_q[raddr_i + AW'(k)];
    end
  end

endmodule

// File: rtl/fifo_sync_nconv.sv
// Single-clock FIFO packing or unpacking NSIZE-symbol words; read data registered, 1-cycle latency.
// Rejected writes/reads are dropped and recorded in sticky overflow/underflow flags.
module fifo_sync_nconv
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int NSIZE     = 4,
  parameter int MODE      = 0,
  parameter int DEPTH     = 16,
  parameter int ALMOST    = 4,
  parameter int DEF_VALUE = 0,
  localparam int WW = (MODE == MODE_PACK) ? DSIZE : DSIZE * NSIZE,
  localparam int RW = (MODE == MODE_PACK) ? DSIZE * NSIZE : DSIZE,
  localparam int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [WW-1:0] wr_data,
  input  logic          wr_last,
  output logic          wr_full,
  output logic          wr_almost_full,
  input  logic          rd_en,
  output logic [RW-1:0] rd_data,
  output logic          rd_vld,
  output logic          rd_last,
  output logic          rd_empty,
  output logic          rd_almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = AW + 1;
  localparam int SW = DSIZE + 1;
  localparam int WS = (MODE == MODE_PACK) ? 1 : NSIZE;
  localparam int RS = (MODE == MODE_PACK) ? NSIZE : 1;
  localparam logic [DSIZE-1:0] DEF_SYM  = DSIZE'(DEF_VALUE);
  localparam logic [PW-1:0]    GRP_MASK = PW'(NSIZE - 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_nxt, space;
  logic          wr_acc, rd_acc;

  logic [NSIZE-1:0]    lane_we;
  logic [NSIZE*SW-1:0] lane_dat;
  logic [AW-1:0]       wbase;
  logic [RS*SW-1:0]    ram_rdat;

  logic [RW-1:0] rd_word, rd_data_q, rd_data_d;
  logic          rd_word_last, rd_last_q, rd_last_d;
  logic          rd_vld_q, rd_vld_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;

  // Flags come only from registered pointers, so a read never frees space for a same-cycle write.
  assign count           = wr_ptr_q - rd_ptr_q;
  assign space           = PW'(DEPTH) - count;
  assign wr_full         = space < PW'(WS);
  assign rd_empty        = count < PW'(RS);
  assign wr_almost_full  = space <= PW'(ALMOST);
  assign rd_almost_empty = count <= PW'(ALMOST);

  assign wr_acc = wr_en && !wr_full;
  assign rd_acc = rd_en && !rd_empty;

  generate
    if (MODE == MODE_PACK) begin : g_pack
      logic [PW-1:0] woff;
      assign woff = wr_ptr_q & GRP_MASK;

      // A last symbol pads the rest of its group so the reader always sees whole words.
      always_comb begin
        lane_we  = '0;
        lane_dat = '0;
        for (int j = 0; j < NSIZE; j++) begin
          if (PW'(j) == woff) begin
            lane_we[j]            = wr_acc;
            lane_dat[j*SW +: SW]  = {wr_last, wr_data};
          end else if (PW'(j) > woff) begin
            lane_we[j]            = wr_acc && wr_last;
            lane_dat[j*SW +: SW]  = {1'b0, DEF_SYM};
          end
        end
      end

      assign wr_nxt = wr_last ? (wr_ptr_q & ~GRP_MASK) + PW'(NSIZE)
                              : wr_ptr_q + PW'(1);
    end else begin : g_unpack
      // Symbol 0 sits in the MSB lane; only the final symbol carries the packet marker.
      always_comb begin
        lane_we  = {NSIZE{wr_acc}};
        lane_dat = '0;
        for (int j = 0; j < NSIZE; j++) begin
          lane_dat[j*SW +: SW] = {(j == NSIZE - 1) && wr_last,
                                  wr_data[(NSIZE-1-j)*DSIZE +: DSIZE]};
        end
      end

      assign wr_nxt = wr_ptr_q + PW'(NSIZE);
    end
  endgenerate

  assign wbase    = wr_ptr_q[AW-1:0] & ~AW'(NSIZE - 1);
  assign wr_ptr_d = wr_acc ? wr_nxt : wr_ptr_q;
  assign rd_ptr_d = rd_acc ? rd_ptr_q + PW'(RS) : rd_ptr_q;

  fifo_sym_ram #(
    .DSIZE (DSIZE),
    .NSIZE (NSIZE),
    .DEPTH (DEPTH),
    .RS    (RS),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (lane_we),
    .wbase_i (wbase),
    .wdat_i  (lane_dat),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdat_o  (ram_rdat)
  );

  always_comb begin
    rd_word      = '0;
    rd_word_last = 1'b0;
    for (int k = 0; k < RS; k++) begin
      rd_word[(RS-1-k)*DSIZE +: DSIZE] = ram_rdat[k*SW +: DSIZE];
      rd_word_last                     = rd_word_last | ram_rdat[k*SW + DSIZE];
    end
  end

  always_comb begin
    rd_vld_d    = rd_acc;
    rd_data_d   = rd_acc ? rd_word : rd_data_q;
    rd_last_d   = rd_acc ? rd_word_last : rd_last_q;
    overflow_d  = overflow_q  | (wr_en && wr_full);
    underflow_d = underflow_q | (rd_en && rd_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= {RS{DEF_SYM}};
      rd_last_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      rd_vld_q    <= rd_vld_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign rd_vld    = rd_vld_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync_nconv.sv
// Bench for fifo_sync_nconv: one unpacking and one packing instance with a read scoreboard each.
module tb_fifo_sync_nconv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_wr_en = 0, a_wr_last = 0, a_rd_en = 0;
  logic [31:0] a_wr_data = '0;
  logic        a_wr_full, a_wr_af, a_rd_vld, a_rd_last, a_rd_empty, a_rd_ae, a_ovf, a_unf;
  logic [7:0]  a_rd_data;
  logic [4:0]  a_count;

  logic        b_wr_en = 0, b_wr_last = 0, b_rd_en = 0;
  logic [7:0]  b_wr_data = '0;
  logic        b_wr_full, b_wr_af, b_rd_vld, b_rd_last, b_rd_empty, b_rd_ae, b_ovf, b_unf;
  logic [31:0] b_rd_data;
  logic [4:0]  b_count;

  fifo_sync_nconv #(.DSIZE(8), .NSIZE(4), .MODE(0), .DEPTH(16), .ALMOST(4), .DEF_VALUE(0)) u_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .wr_last(a_wr_last),
    .wr_full(a_wr_full), .wr_almost_full(a_wr_af), .rd_en(a_rd_en), .rd_data(a_rd_data),
    .rd_vld(a_rd_vld), .rd_last(a_rd_last), .rd_empty(a_rd_empty), .rd_almost_empty(a_rd_ae),
    .count(a_count), .overflow(a_ovf), .underflow(a_unf));

  fifo_sync_nconv #(.DSIZE(8), .NSIZE(4), .MODE(1), .DEPTH(16), .ALMOST(4), .DEF_VALUE(0)) u_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_last(b_wr_last),
    .wr_full(b_wr_full), .wr_almost_full(b_wr_af), .rd_en(b_rd_en), .rd_data(b_rd_data),
    .rd_vld(b_rd_vld), .rd_last(b_rd_last), .rd_empty(b_rd_empty), .rd_almost_empty(b_rd_ae),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf));

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
  } exp_t;

  exp_t aq[$];
  exp_t bq[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    a_wr_en = 0; a_rd_en = 0; a_wr_last = 0;
    b_wr_en = 0; b_rd_en = 0; b_wr_last = 0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic a_wr(input logic [31:0] d, input logic l);
    a_wr_en = 1; a_wr_data = d; a_wr_last = l;
    tick;
    a_wr_en = 0; a_wr_last = 0;
  endtask

  task automatic a_rd(input logic [7:0] d, input logic l);
    exp_t e;
    e.dat = {24'h0, d};
    e.last = l;
    aq.push_back(e);
    a_rd_en = 1;
    tick;
    a_rd_en = 0;
  endtask

  task automatic b_wr(input logic [7:0] d, input logic l);
    b_wr_en = 1; b_wr_data = d; b_wr_last = l;
    tick;
    b_wr_en = 0; b_wr_last = 0;
  endtask

  task automatic b_rd(input logic [31:0] d, input logic l);
    exp_t e;
    e.dat = d;
    e.last = l;
    bq.push_back(e);
    b_rd_en = 1;
    tick;
    b_rd_en = 0;
  endtask

  // Scoreboard monitors: every presented read word must match the oldest expectation.
  always @(negedge clk) begin
    if (a_rd_vld === 1'b1) begin
      if (aq.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_read: got rd_vld=1 data %0h, required no read", a_rd_data);
      end else begin
        ea = aq.pop_front();
        chk("a_rd_data", {24'h0, a_rd_data}, ea.dat);
        chk("a_rd_last", {31'h0, a_rd_last}, {31'h0, ea.last});
      end
    end
  end

  always @(negedge clk) begin
    if (b_rd_vld === 1'b1) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_read: got rd_vld=1 data %0h, required no read", b_rd_data);
      end else begin
        eb = bq.pop_front();
        chk("b_rd_data", b_rd_data, eb.dat);
        chk("b_rd_last", {31'h0, b_rd_last}, {31'h0, eb.last});
      end
    end
  end

  initial begin
    logic [7:0] wseq, rseq, s0, s1, s2, s3;
    int cnt;

    // Reset state and a single unpacked packet.
    do_reset;
    chk("t1_rd_empty", a_rd_empty, 1);
    chk("t1_count", a_count, 0);
    chk("t1_rd_data", a_rd_data, 0);
    chk("t1_wr_full", a_wr_full, 0);
    chk("t1_rd_almost_empty", a_rd_ae, 1);
    chk("t1_wr_almost_full", a_wr_af, 0);
    chk("t1_flags", {a_rd_vld, a_rd_last, a_ovf, a_unf}, 0);
    chk("t1_b_rd_empty", b_rd_empty, 1);
    chk("t1_b_rd_data", b_rd_data, 0);
    a_wr(32'hA1B2C3D4, 1);
    chk("t1_count_w", a_count, 4);
    a_rd(8'hA1, 0); chk("t1_count_r1", a_count, 3);
    a_rd(8'hB2, 0); chk("t1_count_r2", a_count, 2);
    a_rd(8'hC3, 0); chk("t1_count_r3", a_count, 1);
    a_rd(8'hD4, 1); chk("t1_count_r4", a_count, 0);

    // Fill, overflow, and full release after one word's worth of reads.
    do_reset;
    a_wr(32'h10111213, 0);
    a_wr(32'h20212223, 0);
    a_wr(32'h30313233, 0);
    a_wr(32'h40414243, 1);
    chk("t2_count_full", a_count, 16);
    chk("t2_wr_full", a_wr_full, 1);
    chk("t2_ovf_before", a_ovf, 0);
    a_wr(32'hDEADBEEF, 0);
    chk("t2_overflow", a_ovf, 1);
    chk("t2_count_drop", a_count, 16);
    a_rd(8'h10, 0);
    chk("t2_count_r1", a_count, 15);
    chk("t2_full_r1", a_wr_full, 1);
    a_rd(8'h11, 0); a_rd(8'h12, 0); a_rd(8'h13, 0);
    chk("t2_count_r4", a_count, 12);
    chk("t2_full_r4", a_wr_full, 0);
    for (int i = 1; i < 4; i++)
      for (int j = 0; j < 4; j++)
        a_rd(8'(16 * (i + 1) + j), (i == 3) && (j == 3));
    chk("t2_drained", a_rd_empty, 1);

    // Packing with flush at several group offsets.
    do_reset;
    b_wr(8'h11, 0); b_wr(8'h22, 0); b_wr(8'h33, 0);
    chk("t3_partial_empty", b_rd_empty, 1);
    chk("t3_partial_count", b_count, 3);
    b_wr(8'h44, 0);
    chk("t3_count4", b_count, 4);
    b_rd(32'h11223344, 0);
    chk("t3_count0", b_count, 0);
    b_wr(8'h55, 0); b_wr(8'h66, 1);
    chk("t3_flush_count", b_count, 4);
    chk("t3_flush_empty", b_rd_empty, 0);
    b_rd(32'h55660000, 1);
    b_wr(8'h01, 0); b_wr(8'h02, 0); b_wr(8'h03, 0); b_wr(8'h04, 1);
    chk("t3_full_group_count", b_count, 4);
    b_rd(32'h01020304, 1);
    b_wr(8'h77, 1);
    chk("t3_flush0_count", b_count, 4);
    b_rd(32'h77000000, 1);
    chk("t3_end_count", b_count, 0);

    // Simultaneous read/write and a stream across the pointer wrap.
    do_reset;
    a_wr(32'h50515253, 0);
    a_wr(32'h54555657, 0);
    chk("t4_count8", a_count, 8);
    ea.dat = 32'h50; ea.last = 1'b0;
    aq.push_back(ea);
    a_wr_en = 1; a_wr_data = 32'h58595A5B; a_rd_en = 1;
    tick;
    a_wr_en = 0; a_rd_en = 0;
    chk("t4_count11", a_count, 11);
    wseq = 8'h5C; rseq = 8'h51; cnt = 11;
    for (int i = 0; i < 40; i++) begin
      exp_t e;
      e.dat = {24'h0, rseq};
      e.last = 1'b0;
      aq.push_back(e);
      rseq = rseq + 8'd1;
      cnt = cnt - 1;
      a_rd_en = 1;
      if (i % 4 == 0) begin
        s0 = wseq; s1 = wseq + 8'd1; s2 = wseq + 8'd2; s3 = wseq + 8'd3;
        a_wr_en = 1; a_wr_data = {s0, s1, s2, s3};
        wseq = wseq + 8'd4;
        cnt = cnt + 4;
      end
      tick;
      a_wr_en = 0; a_rd_en = 0;
      chk("t4_stream_count", a_count, cnt);
    end
    chk("t4_no_overflow", a_ovf, 0);
    chk("t4_no_underflow", a_unf, 0);
    while (cnt > 0) begin
      a_rd(rseq, 0);
      rseq = rseq + 8'd1;
      cnt = cnt - 1;
    end
    chk("t4_drained", a_rd_empty, 1);

    // Underflow with held output, then reset in mid-operation.
    do_reset;
    a_wr(32'hCAFEBEEF, 0);
    a_rd(8'hCA, 0); a_rd(8'hFE, 0); a_rd(8'hBE, 0); a_rd(8'hEF, 0);
    a_rd_en = 1;
    tick;
    a_rd_en = 0;
    chk("t5_rej_vld", a_rd_vld, 0);
    chk("t5_rej_hold", a_rd_data, 8'hEF);
    chk("t5_underflow", a_unf, 1);
    a_wr(32'h61626364, 0);
    a_wr(32'h65666768, 1);
    chk("t5_count8", a_count, 8);
    rst = 1; a_wr_en = 1; a_wr_data = 32'h71727374; a_rd_en = 1;
    tick;
    rst = 0; a_wr_en = 0; a_rd_en = 0;
    chk("t5_rst_count", a_count, 0);
    chk("t5_rst_empty", a_rd_empty, 1);
    chk("t5_rst_underflow", a_unf, 0);
    chk("t5_rst_vld", a_rd_vld, 0);
    chk("t5_rst_data", a_rd_data, 0);
    a_rd_en = 1;
    tick;
    a_rd_en = 0;
    chk("t5_post_rst_underflow", a_unf, 1);
    chk("t5_post_rst_vld", a_rd_vld, 0);
    a_wr(32'h01020304, 1);
    a_rd(8'h01, 0); a_rd(8'h02, 0); a_rd(8'h03, 0); a_rd(8'h04, 1);

    // Almost flags in pack mode across the full count range.
    do_reset;
    for (int c = 0; c <= 16; c++) begin
      chk("t6_count", b_count, c);
      chk("t6_almost_empty", b_rd_ae, c <= 4);
      chk("t6_almost_full", b_wr_af, c >= 12);
      chk("t6_rd_empty", b_rd_empty, c < 4);
      chk("t6_wr_full", b_wr_full, c == 16);
      if (c < 16) b_wr(8'(c), 0);
    end
    for (int k = 0; k < 4; k++)
      b_rd({8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)}, 0);
    chk("t6_end_count", b_count, 0);
    chk("t6_flags", {b_ovf, b_unf}, 0);

    repeat (3) tick;
    chk("a_queue_drained", aq.size(), 0);
    chk("b_queue_drained", bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
